emesh_acc_initiator: RTL and testbench



---
 rtl/emesh_acc_initiator.sv | 167 ++++++++++++++++
 tb/tb_emesh_acc_initiator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/emesh_acc_initiator.sv
// emesh_acc_initiator: emesh master that writes four operands to the accelerator and reads back its result.
// Optional response watchdog is enabled by defining ACC_TIMEOUT_EN.
`ifndef EGROUP_MMR
`define EGROUP_MMR 4'hB
`endif
`ifndef REG_INPUT0
`define REG_INPUT0 6'd0
`endif
`ifndef REG_INPUT1
`define REG_INPUT1 6'd1
`endif
`ifndef REG_INPUT2
`define REG_INPUT2 6'd2
`endif
`ifndef REG_INPUT3
`define REG_INPUT3 6'd3
`endif
`ifndef REG_OUTPUT
`define REG_OUTPUT 6'd4
`endif

module emesh_acc_initiator #(
  parameter int AW = 32,
  parameter int PW = 2*AW+40,
  parameter logic [11:0] ID = 12'h810,
  parameter logic [3:0] GROUP = `EGROUP_MMR,
  parameter logic [AW-1:0] RADDR = '0,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic [31:0]   op0,
  input  logic [31:0]   op1,
  input  logic [31:0]   op2,
  input  logic [31:0]   op3,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   result,
  output logic          m_wr_access,
  output logic [PW-1:0] m_wr_packet,
  input  logic          m_wr_wait,
  output logic          m_rd_access,
  output logic [PW-1:0] m_rd_packet,
  input  logic          m_rd_wait,
  input  logic          m_rr_access,
  input  logic [PW-1:0] m_rr_packet,
  output logic          m_rr_wait
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0][31:0] op_q, op_d;
  logic busy_q, busy_d, done_q, done_d, wr_q, wr_d, rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [5:0] wr_reg;
  logic unused_ok;
`ifdef ACC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  function automatic logic [31:0] reg_addr(input logic [5:0] r);
    return {ID, GROUP, 8'h00, r, 2'b00};
  endfunction

  always_comb wr_reg = idx_q == 2'd0 ? `REG_INPUT0 : idx_q == 2'd1 ? `REG_INPUT1 :
                       idx_q == 2'd2 ? `REG_INPUT2 : `REG_INPUT3;

  // Standard emesh layout: {srcaddr, data, dstaddr, ctrlmode, datamode, write}
  assign m_wr_packet = {{AW{1'b0}}, op_q[idx_q], reg_addr(wr_reg), 5'b0, 2'b10, 1'b1};
  assign m_rd_packet = {RADDR, 32'h0, reg_addr(`REG_OUTPUT), 5'b0, 2'b10, 1'b0};
  assign m_wr_access = wr_q;
  assign m_rd_access = rd_q;
  assign m_rr_wait   = 1'b0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign unused_ok   = ^{m_rr_packet[PW-1:72], m_rr_packet[39:0], TIMEOUT[0]};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_d     = wr_q;
    rd_d     = rd_q;
    result_d = result_q;
`ifdef ACC_TIMEOUT_EN
    cnt_d     = state_q == RESP ? cnt_q + 1'b1 : '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      // A start coinciding with the done pulse is dropped
      IDLE: if (start && !done_q) begin
        op_d    = {op3, op2, op1, op0};
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        idx_d   = 2'd0;
        state_d = WRITE;
      end
      WRITE: if (!m_wr_wait) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          state_d = READ;
        end
      end
      READ: if (!m_rd_wait) begin
        rd_d    = 1'b0;
        state_d = RESP;
      end
      RESP: if (m_rr_access) begin
        result_d = m_rr_packet[71:40];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
`ifdef ACC_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT-1)) begin
        done_d    = 1'b1;
        timeout_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      result_q <= '0;
`ifdef ACC_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      result_q <= result_d;
`ifdef ACC_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end
endmodule

// File: tb/tb_emesh_acc_initiator.sv
// tb_emesh_acc_initiator: table-driven bench with a write/read scoreboard and a modelled responder.
module tb_emesh_acc_initiator;
  localparam int PW = 104;
  localparam logic [31:0] ADDR0 = 32'h8100_0000;
  localparam logic [31:0] RADDR_OUT = 32'h8100_0010;
  localparam logic [31:0] STRAY = 32'hBAD0_BAD0;

  logic clk = 0, nreset = 0, start = 0;
  logic [31:0] op0 = 0, op1 = 0, op2 = 0, op3 = 0;
  logic busy, done, timeout;
  logic [31:0] result;
  logic m_wr_access, m_wr_wait = 0, m_rd_access, m_rd_wait = 0;
  logic [PW-1:0] m_wr_packet, m_rd_packet;
  logic m_rr_access = 0, m_rr_wait;
  logic [PW-1:0] m_rr_packet = '0;

  emesh_acc_initiator #(.GROUP(4'h0), .TIMEOUT(16)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .op0(op0), .op1(op1), .op2(op2), .op3(op3),
    .busy(busy), .done(done), .timeout(timeout), .result(result),
    .m_wr_access(m_wr_access), .m_wr_packet(m_wr_packet), .m_wr_wait(m_wr_wait),
    .m_rd_access(m_rd_access), .m_rd_packet(m_rd_packet), .m_rd_wait(m_rd_wait),
    .m_rr_access(m_rr_access), .m_rr_packet(m_rr_packet), .m_rr_wait(m_rr_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] op;
    int wr_idx;
    int wr_len;
    int rd_len;
    bit stray;
    bit restart;
    bit rsp_en;
    logic [31:0] rsp;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] wr_exp[$];
  bit rd_exp[$];
  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, wr_base = 0;
  int wr_hold = 0, rd_hold = 0, wait_idx = -1;
  bit rd_fire = 0, rsp_en = 0, stray_req = 0;
  logic [31:0] rsp_data = 0;
  bit wr_stall_prev = 0, rd_stall_prev = 0;
  logic [PW-1:0] wr_pkt_prev, rd_pkt_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard for issued packets, hold-stability and access exclusivity
  always @(negedge clk) begin
    logic [63:0] e;
    if (m_wr_access || m_rd_access) chk("one_access", {31'b0, m_wr_access & m_rd_access}, 0);
    if (wr_stall_prev) chk("wr_hold", {31'b0, m_wr_access && m_wr_packet == wr_pkt_prev}, 1);
    if (rd_stall_prev) chk("rd_hold", {31'b0, m_rd_access && m_rd_packet == rd_pkt_prev}, 1);
    wr_stall_prev = nreset && m_wr_access && m_wr_wait;
    rd_stall_prev = nreset && m_rd_access && m_rd_wait;
    wr_pkt_prev = m_wr_packet;
    rd_pkt_prev = m_rd_packet;
    rd_fire = nreset && m_rd_access && !m_rd_wait;
    if (nreset && m_wr_access && !m_wr_wait) begin
      wr_cnt++;
      if (wr_exp.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        e = wr_exp.pop_front();
        chk("wr_addr", m_wr_packet[39:8], e[63:32]);
        chk("wr_data", m_wr_packet[71:40], e[31:0]);
        chk("wr_ctrl", {24'b0, m_wr_packet[7:0]}, 32'h05);
        chk("wr_src", m_wr_packet[103:72], 0);
      end
    end
    if (rd_fire) begin
      rd_cnt++;
      if (rd_exp.size() == 0) chk("unexpected_rd", 1, 0);
      else begin
        void'(rd_exp.pop_front());
        chk("rd_addr", m_rd_packet[39:8], RADDR_OUT);
        chk("rd_ctrl", {24'b0, m_rd_packet[7:0]}, 32'h04);
        chk("rd_src", m_rd_packet[103:72], 0);
        chk("rd_data", m_rd_packet[71:40], 0);
      end
    end
    if (done) done_cnt++;
  end

  // Responder: answers one cycle after a read transfer, or injects a stray pulse on request
  always @(posedge clk) begin
    #2;
    m_rr_access = 0;
    if ((rd_fire && rsp_en) || stray_req) begin
      m_rr_access = 1;
      m_rr_packet = {32'h0, (rd_fire && rsp_en) ? rsp_data : STRAY, 32'h0, 8'h05};
    end
  end

  task automatic run_vec(input vec_t t);
    int n, d0, r0;
    bit got;
    logic [31:0] prev;
    prev = result;
    d0 = done_cnt;
    r0 = rd_cnt;
    wr_base = wr_cnt;
    for (int i = 0; i < 4; i++) wr_exp.push_back({ADDR0 + 32'(4*i), t.op[i]});
    rd_exp.push_back(1'b1);
    rsp_en = t.rsp_en;
    rsp_data = t.rsp;
    wr_hold = t.wr_len;
    rd_hold = t.rd_len;
    wait_idx = t.wr_idx;
    {op3, op2, op1, op0} = t.op;
    start = 1;
    tick();
    start = 0;
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      m_wr_wait = m_wr_access && (wr_cnt - wr_base) == wait_idx && wr_hold > 0;
      if (m_wr_wait) wr_hold--;
      m_rd_wait = m_rd_access && rd_hold > 0;
      if (m_rd_wait) rd_hold--;
      start = t.restart && n == 1;
      if (start) {op3, op2, op1, op0} = ~t.op;
      stray_req = t.stray && n == 1;
      tick();
      n++;
      if (t.stray && n == 3) chk("stray_ignored", result, prev);
      got = done;
    end
    start = 0;
    stray_req = 0;
    m_wr_wait = 0;
    m_rd_wait = 0;
    chk("done_seen", {31'b0, got}, 1);
    chk("latency", n, t.rsp_en ? 6 + t.wr_len + t.rd_len : 21 + t.wr_len + t.rd_len);
    chk("result", result, t.rsp_en ? t.rsp : prev);
    chk("timeout_flag", {31'b0, timeout}, {31'b0, !t.rsp_en});
    chk("busy_at_done", {31'b0, busy}, 0);
    // start coinciding with done must be ignored
    {op3, op2, op1, op0} = 128'h1;
    start = 1;
    tick();
    start = 0;
    chk("done_one_pulse", {31'b0, done}, 0);
    chk("start_on_done_busy", {31'b0, busy}, 0);
    chk("start_on_done_wr", {31'b0, m_wr_access}, 0);
    repeat (3) tick();
    chk("wr_count", wr_cnt - wr_base, 4);
    chk("rd_count", rd_cnt - r0, 1);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    vec_t v;
    int d0;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_timeout", {31'b0, timeout}, 0);
    chk("rst_result", result, 0);
    chk("rst_wr", {31'b0, m_wr_access}, 0);
    chk("rst_rd", {31'b0, m_rd_access}, 0);
    chk("rst_rr_wait", {31'b0, m_rr_wait}, 0);
    chk("rst_op0", m_wr_packet[71:40], 0);
    nreset = 1;
    tick();

    v = '{op: {32'd4, 32'd3, 32'd2, 32'd1}, wr_idx: -1, wr_len: 0, rd_len: 0,
          stray: 0, restart: 0, rsp_en: 1, rsp: 32'h0000_000A};
    vecs.push_back(v);
    v = '{op: {32'h44, 32'h33, 32'h22, 32'h11}, wr_idx: 1, wr_len: 3, rd_len: 0,
          stray: 0, restart: 0, rsp_en: 1, rsp: 32'h0000_00AA};
    vecs.push_back(v);
    v = '{op: {32'hA5A5_0003, 32'h5A5A_0002, 32'hF0F0_0001, 32'h0F0F_0000}, wr_idx: -1, wr_len: 0,
          rd_len: 5, stray: 1, restart: 0, rsp_en: 1, rsp: 32'hDEAD_BEEF};
    vecs.push_back(v);
    v = '{op: {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001}, wr_idx: -1, wr_len: 0,
          rd_len: 0, stray: 0, restart: 1, rsp_en: 1, rsp: 32'h1234_5678};
    vecs.push_back(v);
    v = '{op: {32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFE}, wr_idx: 3, wr_len: 2,
          rd_len: 2, stray: 1, restart: 1, rsp_en: 1, rsp: 32'h8000_0001};
    vecs.push_back(v);
`ifdef ACC_TIMEOUT_EN
    v = '{op: {32'd8, 32'd7, 32'd6, 32'd5}, wr_idx: -1, wr_len: 0, rd_len: 0,
          stray: 0, restart: 0, rsp_en: 0, rsp: 32'h0};
    vecs.push_back(v);
    v = '{op: {32'd9, 32'd9, 32'd9, 32'd9}, wr_idx: -1, wr_len: 0, rd_len: 0,
          stray: 0, restart: 0, rsp_en: 1, rsp: 32'h0000_0024};
    vecs.push_back(v);
`endif
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the read is stalled; a late response must be ignored
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) wr_exp.push_back({ADDR0 + 32'(4*i), 32'h100 + 32'(i)});
    rd_exp.push_back(1'b1);
    rsp_en = 0;
    {op3, op2, op1, op0} = {32'h103, 32'h102, 32'h101, 32'h100};
    start = 1;
    tick();
    start = 0;
    m_rd_wait = 1;
    repeat (6) tick();
    chk("rd_pending", {31'b0, m_rd_access}, 1);
    nreset = 0;
    tick();
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_wr", {31'b0, m_wr_access}, 0);
    chk("mid_rst_rd", {31'b0, m_rd_access}, 0);
    chk("mid_rst_done", {31'b0, done}, 0);
    chk("mid_rst_result", result, 0);
    nreset = 1;
    m_rd_wait = 0;
    rd_exp.delete();
    wr_exp.delete();
    stray_req = 1;
    tick();
    stray_req = 0;
    repeat (3) tick();
    chk("late_rsp_result", result, 0);
    chk("late_rsp_done", done_cnt - d0, 0);
    chk("late_rsp_busy", {31'b0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
